instr_fetch: RTL

//  Fetch stage downstream of the PC counter. Reads the current PC (a word index), issues one

---
 rtl/instr_fetch.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage that sits between the PC counter and decode. It issues one
//   instruction-memory request at a time. It pulses the counter enable when the
//   memory grants that request. Returned {pc, instr} pairs are buffered in a
//   small instruction queue (IFQ) that feeds decode. A flush drops everything
//   that is queued or in flight.
//
// Parameters
//   WIDTH  PC / address / instruction width
//   DEPTH  instruction-queue entries (power of 2, >= 2)
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   pc_i             current PC (word index) from the counter
//   pc_en_o          one-cycle counter-enable pulse per granted request
//   flush_i          discard the queue and any outstanding fetch
//   mem_req_o        memory request valid
//   mem_addr_o       request address (pc_i while mem_req_o is high, else 0)
//   mem_gnt_i        request accepted (only looked at while mem_req_o = 1)
//   mem_rvalid_i     read data valid
//   mem_rdata_i      read data
//   ifq_valid_o      queue head valid
//   ifq_instr_o      head instruction
//   ifq_pc_o         head PC
//   ifq_ready_i      decode pops the head on ifq_valid_o & ifq_ready_i
//   ifq_count_o      number of occupied queue entries
//
// Build option
//   IFQ_BYPASS_EN  When defined, a response that arrives while the queue is
//                  empty is shown on the ifq outputs in the same cycle. If
//                  decode takes it in that cycle, it is never written to the
//                  queue. When undefined, the ifq outputs come from registers
//                  only.
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [WIDTH-1:0]           pc_i,
  output logic                       pc_en_o,
  input  logic                       flush_i,
  output logic                       mem_req_o,
  output logic [WIDTH-1:0]           mem_addr_o,
  input  logic                       mem_gnt_i,
  input  logic                       mem_rvalid_i,
  input  logic [WIDTH-1:0]           mem_rdata_i,
  output logic                       ifq_valid_o,
  output logic [WIDTH-1:0]           ifq_instr_o,
  output logic [WIDTH-1:0]           ifq_pc_o,
  input  logic                       ifq_ready_i,
  output logic [$clog2(DEPTH):0]     ifq_count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] pc_mem_q    [DEPTH];
  logic [WIDTH-1:0] instr_mem_q [DEPTH];

  logic rsp_ok, bypass_hit, head_valid, pop, push, slot_free;

  // NOTE: every signal written in an always_comb block gets a default value
  // first. An assignment that is missing on some path would otherwise infer a
  // latch.
  always_comb begin
    // A response is usable only in WAIT and only when it is not being flushed.
    rsp_ok     = (state_q == S_WAIT) && mem_rvalid_i && !flush_i;
`ifdef IFQ_BYPASS_EN
    bypass_hit = rsp_ok && (count_q == '0);
`else
    bypass_hit = 1'b0;
`endif
    head_valid = (count_q != '0);
    pop        = head_valid && ifq_ready_i && !flush_i;
    // A bypassed response that decode takes this cycle never enters the queue.
    push       = rsp_ok && !(bypass_hit && ifq_ready_i);

    count_d  = flush_i ? '0 : count_q + CW'(push) - CW'(pop);
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(pop);
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(push);
    // The slot test looks at the occupancy after this cycle's push and pop.
    // A new request therefore always has a free entry reserved for its data.
    slot_free = (count_d < FULL);

    state_d   = state_q;
    mem_req_o = 1'b0;
    pc_en_o   = 1'b0;
    unique case (state_q)
      S_IDLE: if (!flush_i && slot_free) state_d = S_REQ;
      S_REQ: begin
        mem_req_o = !flush_i;
        if (flush_i) begin
          state_d = S_IDLE;
        end else if (mem_gnt_i) begin
          pc_en_o = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // If the response arrives in the flush cycle, it is discarded here.
        // There is then no later beat left for DROP to wait on.
        if (flush_i)           state_d = mem_rvalid_i ? S_IDLE : S_DROP;
        else if (mem_rvalid_i) state_d = slot_free ? S_REQ : S_IDLE;
      end
      S_DROP: if (mem_rvalid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    mem_addr_o = mem_req_o ? pc_i : '0;
    req_pc_d   = pc_en_o ? pc_i : req_pc_q;

    ifq_valid_o = head_valid || bypass_hit;
    ifq_count_o = count_q;
    ifq_pc_o    = '0;
    ifq_instr_o = '0;
    if (bypass_hit) begin
      ifq_pc_o    = req_pc_q;
      ifq_instr_o = mem_rdata_i;
    end else if (head_valid) begin
      ifq_pc_o    = pc_mem_q[rd_ptr_q];
      ifq_instr_o = instr_mem_q[rd_ptr_q];
    end
  end

  // NOTE: state registers use non-blocking assignments. Every flop then
  // samples its pre-edge value, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      req_pc_q <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the queue storage has no reset. The outputs are gated by
  // occupancy, so a stale entry is never visible, and the array can map onto
  // plain flops or RAM without reset wiring.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= mem_rdata_i;
    end
  end

endmodule
